// File: rtl/matmul_stream.sv
// Streaming signed matrix multiplier C = A x B with on-chip A/B/C buffers and valid/ready streams.
// Optional macro MATMUL_SAT_EN clamps each stored C element to the signed DW range.
module matmul_stream #(
    parameter int DW       = 16,
    parameter int ACC_W    = 40,
    parameter int BUF_SIZE = 1024,
    parameter int DIM_W    = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [DIM_W-1:0]        dim_m,
    input  logic [DIM_W-1:0]        dim_k,
    input  logic [DIM_W-1:0]        dim_n,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic signed [DW-1:0]    a_data,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic signed [DW-1:0]    b_data,
    output logic                    c_valid,
    input  logic                    c_ready,
    output logic [ACC_W-1:0]        c_data,
    output logic [2:0]              state,
    output logic                    err
);

    localparam int AW = $clog2(BUF_SIZE);
    localparam int CW = AW + 1;
    localparam int XW = 2 * DIM_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CALC  = 3'd2,
        S_WRITE = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t                   r_state;
    logic                     r_err;
    logic                     r_cValid;
    logic [ACC_W-1:0]         r_cData;
    logic [CW-1:0]            r_aCnt, r_bCnt, r_mk, r_kn, r_mn;
    logic [XW-1:0]            r_mnk, r_calcCnt;
    logic [DIM_W-1:0]         r_k, r_n, r_kIdx, r_jIdx;
    logic [AW-1:0]            r_aRow, r_aAddr, r_bAddr, r_cIdx, r_opCIdx, r_outIdx;
    logic signed [DW-1:0]     r_opA, r_opB;
    logic                     r_opValid, r_opLast;
    logic signed [ACC_W-1:0]  r_acc;

    logic signed [DW-1:0]     r_memA [BUF_SIZE];
    logic signed [DW-1:0]     r_memB [BUF_SIZE];
    logic [ACC_W-1:0]         r_memC [BUF_SIZE];

    logic [XW-1:0]            w_mExt, w_kExt, w_nExt, w_mk, w_kn, w_mn, w_mnk;
    logic                     w_dimsOk, w_aFire, w_bFire, w_aDone, w_bDone, w_store;
    logic signed [2*DW-1:0]   w_prod;
    logic signed [ACC_W-1:0]  w_prodExt, w_sum, w_storeVal;

    assign w_mExt   = {{DIM_W{1'b0}}, dim_m};
    assign w_kExt   = {{DIM_W{1'b0}}, dim_k};
    assign w_nExt   = {{DIM_W{1'b0}}, dim_n};
    assign w_mk     = w_mExt * w_kExt;
    assign w_kn     = w_kExt * w_nExt;
    assign w_mn     = w_mExt * w_nExt;
    assign w_mnk    = w_mn * w_kExt;
    assign w_dimsOk = (dim_m != '0) && (dim_k != '0) && (dim_n != '0) &&
                      (w_mk <= XW'(BUF_SIZE)) && (w_kn <= XW'(BUF_SIZE)) && (w_mn <= XW'(BUF_SIZE));

    assign a_ready  = (r_state == S_READ) && (r_aCnt != r_mk);
    assign b_ready  = (r_state == S_READ) && (r_bCnt != r_kn);
    assign w_aFire  = a_valid && a_ready;
    assign w_bFire  = b_valid && b_ready;
    assign w_aDone  = (r_aCnt == r_mk) || (w_aFire && (r_aCnt == r_mk - 1'b1));
    assign w_bDone  = (r_bCnt == r_kn) || (w_bFire && (r_bCnt == r_kn - 1'b1));

    // Accumulator keeps wrapping; only the value written into the C buffer is clamped.
    assign w_prod    = r_opA * r_opB;
    assign w_prodExt = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
    assign w_sum     = r_acc + w_prodExt;
    assign w_store   = (r_state == S_CALC) && r_opValid && r_opLast;

`ifdef MATMUL_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DW-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        w_storeVal = w_sum;
        if (w_sum > SAT_MAX)
            w_storeVal = SAT_MAX;
        else if (w_sum < SAT_MIN)
            w_storeVal = SAT_MIN;
    end
`else
    assign w_storeVal = w_sum;
`endif

    always_ff @(posedge clk) begin
        if (w_aFire)
            r_memA[r_aCnt[AW-1:0]] <= a_data;
        if (w_bFire)
            r_memB[r_bCnt[AW-1:0]] <= b_data;
        if (w_store)
            r_memC[r_opCIdx] <= w_storeVal;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_err     <= 1'b0;
            r_cValid  <= 1'b0;
            r_cData   <= '0;
            r_aCnt    <= '0;
            r_bCnt    <= '0;
            r_mk      <= '0;
            r_kn      <= '0;
            r_mn      <= '0;
            r_mnk     <= '0;
            r_calcCnt <= '0;
            r_k       <= '0;
            r_n       <= '0;
            r_kIdx    <= '0;
            r_jIdx    <= '0;
            r_aRow    <= '0;
            r_aAddr   <= '0;
            r_bAddr   <= '0;
            r_cIdx    <= '0;
            r_opCIdx  <= '0;
            r_outIdx  <= '0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_opValid <= 1'b0;
            r_opLast  <= 1'b0;
            r_acc     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_dimsOk) begin
                            r_state <= S_READ;
                            r_aCnt  <= '0;
                            r_bCnt  <= '0;
                            r_k     <= dim_k;
                            r_n     <= dim_n;
                            r_mk    <= CW'(w_mk);
                            r_kn    <= CW'(w_kn);
                            r_mn    <= CW'(w_mn);
                            r_mnk   <= w_mnk;
                        end else begin
                            r_state <= S_ERROR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_ERROR: begin
                    r_state <= S_IDLE;
                    r_err   <= 1'b0;
                end
                S_READ: begin
                    if (w_aFire)
                        r_aCnt <= r_aCnt + 1'b1;
                    if (w_bFire)
                        r_bCnt <= r_bCnt + 1'b1;
                    if (w_aDone && w_bDone) begin
                        r_state   <= S_CALC;
                        r_calcCnt <= '0;
                        r_kIdx    <= '0;
                        r_jIdx    <= '0;
                        r_aRow    <= '0;
                        r_aAddr   <= '0;
                        r_bAddr   <= '0;
                        r_cIdx    <= '0;
                        r_opValid <= 1'b0;
                        r_acc     <= '0;
                    end
                end
                // Walk i/j/k by address stepping: A row base, B column stride N, C index per dot product.
                S_CALC: begin
                    r_calcCnt <= r_calcCnt + 1'b1;
                    if (r_calcCnt < r_mnk) begin
                        r_opA     <= r_memA[r_aAddr];
                        r_opB     <= r_memB[r_bAddr];
                        r_opValid <= 1'b1;
                        r_opLast  <= (r_kIdx == r_k - 1'b1);
                        r_opCIdx  <= r_cIdx;
                        if (r_kIdx == r_k - 1'b1) begin
                            r_kIdx <= '0;
                            r_cIdx <= r_cIdx + 1'b1;
                            if (r_jIdx == r_n - 1'b1) begin
                                r_jIdx  <= '0;
                                r_aRow  <= r_aRow + AW'(r_k);
                                r_aAddr <= r_aRow + AW'(r_k);
                                r_bAddr <= '0;
                            end else begin
                                r_jIdx  <= r_jIdx + 1'b1;
                                r_aAddr <= r_aRow;
                                r_bAddr <= AW'(r_jIdx + 1'b1);
                            end
                        end else begin
                            r_kIdx  <= r_kIdx + 1'b1;
                            r_aAddr <= r_aAddr + 1'b1;
                            r_bAddr <= r_bAddr + AW'(r_n);
                        end
                    end else begin
                        r_opValid <= 1'b0;
                    end
                    if (r_opValid)
                        r_acc <= r_opLast ? '0 : w_sum;
                    if (r_calcCnt == r_mnk + 1'b1) begin
                        r_state  <= S_WRITE;
                        r_cValid <= 1'b1;
                        r_cData  <= r_memC[0];
                        r_outIdx <= '0;
                    end
                end
                S_WRITE: begin
                    if (c_ready) begin
                        if ({1'b0, r_outIdx} == r_mn - 1'b1) begin
                            r_cValid <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_outIdx <= r_outIdx + 1'b1;
                            r_cData  <= r_memC[r_outIdx + 1'b1];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign c_valid = r_cValid;
    assign c_data  = r_cData;
    assign state   = r_state;
    assign err     = r_err;

endmodule

// File: tb/tb_matmul_stream.sv
// Self-checking bench for matmul_stream: dimension-check table, scoreboard on the C stream,
// and hand-written sequences for toggled input, backpressure, mid-CALC reset and saturation/wrap.
module tb_matmul_stream;

    localparam int DW       = 16;
    localparam int ACC_W    = 40;
    localparam int BUF_SIZE = 1024;
    localparam int DIM_W    = 16;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   start = 1'b0;
    logic [DIM_W-1:0]       dim_m = '0, dim_k = '0, dim_n = '0;
    logic                   a_valid = 1'b0, b_valid = 1'b0, c_ready = 1'b0;
    logic                   a_ready, b_ready, c_valid, err;
    logic signed [DW-1:0]   a_data = '0, b_data = '0;
    logic [ACC_W-1:0]       c_data;
    logic [2:0]             state;

    matmul_stream #(.DW(DW), .ACC_W(ACC_W), .BUF_SIZE(BUF_SIZE), .DIM_W(DIM_W)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
        .state(state), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int m;
        int k;
        int n;
        bit expErr;
    } dimVec_t;

    dimVec_t           dimTable [7];
    int                errors = 0;
    int                checks = 0;
    longint            cycleCount = 0;
    logic [ACC_W-1:0]  expQ [$];
    longint            hsCycles [$];
    int                hsCount = 0;
    int                calcCycles = 0;
    logic              stallHeld = 1'b0;
    logic [ACC_W-1:0]  heldData = '0;
    int                matA [BUF_SIZE];
    int                matB [BUF_SIZE];

`ifdef MATMUL_SAT_EN
    localparam longint SAT_HI = (longint'(1) <<< (DW-1)) - 1;
`endif

    function void checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference model: full-precision dot product, wrapped to the accumulator width, optionally clamped.
    function automatic logic [ACC_W-1:0] modelC(input int m, input int k, input int n, input int i, input int j);
        longint s;
        logic signed [ACC_W-1:0] w;
        s = 0;
        for (int kk = 0; kk < k; kk++)
            s += longint'(matA[i*k+kk]) * longint'(matB[kk*n+j]);
        w = s[ACC_W-1:0];
`ifdef MATMUL_SAT_EN
        if (longint'(w) > SAT_HI)
            w = ACC_W'(SAT_HI);
        else if (longint'(w) < -SAT_HI - 1)
            w = ACC_W'(-SAT_HI - 1);
`endif
        return w;
    endfunction

    task automatic pushModel(input int m, input int k, input int n);
        for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++)
                expQ.push_back(modelC(m, k, n, i, j));
    endtask

    always @(posedge clk) cycleCount++;

    // Output monitor: scoreboard pop on every handshake, hold check while stalled, CALC length count.
    always @(negedge clk) begin
        if (rstn) begin
            if (state == 3'd2)
                calcCycles++;
            if (c_valid) begin
                if (stallHeld)
                    checkOutput("stall_stable", 64'(c_data), 64'(heldData));
                stallHeld = !c_ready;
                heldData  = c_data;
            end else begin
                stallHeld = 1'b0;
            end
            if (c_valid && c_ready) begin
                hsCount++;
                hsCycles.push_back(cycleCount);
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got 0x%0h, expected no element", c_data);
                end else begin
                    checkOutput("c_data", 64'(c_data), 64'(expQ.pop_front()));
                end
            end
        end else begin
            stallHeld = 1'b0;
        end
    end

    task automatic startOp(input int m, input int k, input int n);
        dim_m = DIM_W'(m);
        dim_k = DIM_W'(k);
        dim_n = DIM_W'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic applyStimulus(input int m, input int k, input int n, input bit bToggle);
        int aIdx, bIdx, cyc, mk, kn;
        bit aFire, bFire;
        startOp(m, k, n);
        aIdx = 0; bIdx = 0; cyc = 0; mk = m * k; kn = k * n;
        while ((aIdx < mk || bIdx < kn) && cyc < 3000) begin
            a_valid = (aIdx < mk);
            a_data  = (aIdx < mk) ? DW'(matA[aIdx]) : '0;
            b_valid = (bIdx < kn) && (!bToggle || (cyc % 2 == 0));
            b_data  = (bIdx < kn) ? DW'(matB[bIdx]) : '0;
            @(negedge clk);
            aFire = a_valid && a_ready;
            bFire = b_valid && b_ready;
            if (bToggle && bFire && (bIdx == kn - 1))
                checkOutput("read_before_last_b", 64'(state), 64'd1);
            @(posedge clk); #1;
            if (aFire) aIdx++;
            if (bFire) bIdx++;
            cyc++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (aIdx < mk || bIdx < kn) begin
            checks++;
            errors++;
            $display("[TB] FAIL stream_timeout: accepted a=%0d/%0d b=%0d/%0d", aIdx, mk, bIdx, kn);
        end
        checkOutput("calc_after_inputs", 64'(state), 64'd2);
    endtask

    task automatic drainOut(input bit stallMode);
        int cyc, stall;
        cyc = 0; stall = 0;
        while (state != 3'd0 && cyc < 5000) begin
            c_ready = stallMode ? (stall >= 3) : 1'b1;
            @(negedge clk);
            if (c_valid && c_ready)
                stall = 0;
            else if (c_valid)
                stall++;
            @(posedge clk); #1;
            cyc++;
        end
        c_ready = 1'b0;
        checkOutput("idle_after_write", 64'(state), 64'd0);
        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
    endtask

    task automatic resetDut();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        dimTable[0] = '{0, 3, 3, 1'b1};
        dimTable[1] = '{33, 32, 1, 1'b1};
        dimTable[2] = '{3, 3, 0, 1'b1};
        dimTable[3] = '{2, 0, 2, 1'b1};
        dimTable[4] = '{1, 1, 1025, 1'b1};
        dimTable[5] = '{32, 32, 1, 1'b0};
        dimTable[6] = '{1, 1024, 1, 1'b0};

        @(negedge clk);
        checkOutput("rst_state", 64'(state), 64'd0);
        checkOutput("rst_a_ready", 64'(a_ready), 64'd0);
        checkOutput("rst_b_ready", 64'(b_ready), 64'd0);
        checkOutput("rst_c_valid", 64'(c_valid), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_c_data", 64'(c_data), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) begin
            startOp(dimTable[v].m, dimTable[v].k, dimTable[v].n);
            if (dimTable[v].expErr) begin
                checkOutput("err_state", 64'(state), 64'd4);
                checkOutput("err_pulse", 64'(err), 64'd1);
                checkOutput("err_a_ready", 64'(a_ready), 64'd0);
                @(posedge clk); #1;
                checkOutput("err_back_idle", 64'(state), 64'd0);
                checkOutput("err_one_cycle", 64'(err), 64'd0);
            end else begin
                checkOutput("ok_state", 64'(state), 64'd1);
                checkOutput("ok_err", 64'(err), 64'd0);
                checkOutput("ok_a_ready", 64'(a_ready), 64'd1);
                resetDut();
            end
        end

        matA[0] = 1; matA[1] = 2; matA[2] = 3; matA[3] = 4;
        matB[0] = 5; matB[1] = 6; matB[2] = 7; matB[3] = 8;
        expQ.push_back(ACC_W'(19));
        expQ.push_back(ACC_W'(22));
        expQ.push_back(ACC_W'(43));
        expQ.push_back(ACC_W'(50));
        calcCycles = 0;
        hsCount = 0;
        hsCycles.delete();
        applyStimulus(2, 2, 2, 1'b0);
        startOp(0, 3, 3);
        checkOutput("start_ignored_state", 64'(state), 64'd2);
        checkOutput("start_ignored_err", 64'(err), 64'd0);
        drainOut(1'b0);
        checkOutput("calc_cycles", 64'(calcCycles), 64'd10);
        checkOutput("hs_count_2x2", 64'(hsCount), 64'd4);
        if (hsCycles.size() == 4)
            checkOutput("back_to_back", 64'(hsCycles[3] - hsCycles[0]), 64'd3);
        else
            checkOutput("back_to_back_len", 64'(hsCycles.size()), 64'd4);

        matA[0] = 2; matA[1] = -3; matA[2] = 4;
        matB[0] = 5; matB[1] = 6;  matB[2] = -7;
        expQ.push_back(ACC_W'(-36));
        applyStimulus(1, 3, 1, 1'b1);
        drainOut(1'b0);

        matA[0] = 3; matA[1] = -4;
        matB[0] = 5; matB[1] = -6;
        expQ.push_back(ACC_W'(15));
        expQ.push_back(ACC_W'(-18));
        expQ.push_back(ACC_W'(-20));
        expQ.push_back(ACC_W'(24));
        hsCount = 0;
        applyStimulus(2, 1, 2, 1'b0);
        drainOut(1'b1);
        checkOutput("hs_count_stall", 64'(hsCount), 64'd4);

        for (int i = 0; i < 6; i++) begin
            matA[i] = 1000 + i;
            matB[i] = 2000 - i;
        end
        applyStimulus(2, 3, 2, 1'b0);
        repeat (5) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        checkOutput("abort_state", 64'(state), 64'd0);
        checkOutput("abort_c_valid", 64'(c_valid), 64'd0);
        checkOutput("abort_a_ready", 64'(a_ready), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            matA[i] = i - 2;
            matB[i] = 3 * i + 1;
        end
        pushModel(2, 3, 2);
        applyStimulus(2, 3, 2, 1'b0);
        drainOut(1'b0);

        matA[0] = 32767;
        matB[0] = 32767;
`ifdef MATMUL_SAT_EN
        expQ.push_back(ACC_W'(32767));
`else
        expQ.push_back(ACC_W'(1073676289));
`endif
        applyStimulus(1, 1, 1, 1'b0);
        drainOut(1'b0);

        for (int i = 0; i < 512; i++) begin
            matA[i] = -32768;
            matB[i] = -32768;
        end
`ifdef MATMUL_SAT_EN
        expQ.push_back(ACC_W'(-32768));
`else
        expQ.push_back(40'h80_0000_0000);
`endif
        applyStimulus(1, 512, 1, 1'b0);
        drainOut(1'b0);

        for (int i = 0; i < 12; i++) begin
            matA[i] = int'($urandom_range(0, 65535)) - 32768;
            matB[i] = int'($urandom_range(0, 65535)) - 32768;
        end
        pushModel(3, 4, 2);
        applyStimulus(3, 4, 2, 1'b0);
        drainOut(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
